backbone_mult_scheduler: RTL and testbench

Round-robin scheduler that shares one pipelined fixed-point multiplier among NREQ requesters. Each requester needs the serial product of NF selected 8-bit alpha factors, i.e. a backbone-initial value. The block latches one request's factor vector and sequences the multiplier through NF-1 dependent multiplies. It then presents the 32-bit product with the requester ID. It sits between the per-node factor-selection logic and the backbone consumers.

---
 rtl/backbone_sched_pkg.sv | 29 ++
 rtl/backbone_mult_scheduler_mul_fix_pipe.sv | 65 ++++++
 rtl/backbone_mult_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_backbone_mult_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/backbone_sched_pkg.sv
// -----------------------------------------------------------------------------
// backbone_sched_pkg
//   Shared types and fixed-point constants for the backbone multiply scheduler.
//   - state_e      : scheduler FSM states
//   - ACC_W/FAC_W  : accumulator (Q4.28) and factor (Q0.8) widths
//   - LOAD_SHIFT   : shift that places a Q0.8 factor into Q4.28
//   - q08_to_q428  : converts a factor into the accumulator format
// -----------------------------------------------------------------------------
package backbone_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int ACC_W      = 32;
  localparam int FAC_W      = 8;
  localparam int ACC_FRAC   = 28;
  localparam int FAC_FRAC   = 8;
  localparam int LOAD_SHIFT = ACC_FRAC - FAC_FRAC;

  // {4'b0, f, 20'b0}: the same real value, re-expressed with 28 fraction bits.
  function automatic logic [ACC_W-1:0] q08_to_q428(input logic [FAC_W-1:0] f);
    return ACC_W'(f) << LOAD_SHIFT;
  endfunction

endpackage

// File: rtl/backbone_mult_scheduler_mul_fix_pipe.sv
// -----------------------------------------------------------------------------
// mul_fix_pipe
//   Pipelined unsigned fixed-point multiplier, Q4.28 x Q0.8 -> Q4.28.
//   The 40-bit product is shifted right by FAC_FRAC and truncated to 32 bits,
//   then carried through MUL_LAT register stages. No backpressure.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     in_valid     operand strobe
//     in_a [31:0]  accumulator operand (Q4.28)
//     in_b [7:0]   factor operand (Q0.8)
//     out_valid    result strobe, MUL_LAT cycles after in_valid
//     out_data     result (Q4.28)
// -----------------------------------------------------------------------------
module mul_fix_pipe
  import backbone_sched_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [ACC_W-1:0] in_a,
  input  logic [FAC_W-1:0] in_b,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data
);

  logic [ACC_W+FAC_W-1:0]            prod;
  logic [MUL_LAT-1:0]                valid_q, valid_d;
  logic [MUL_LAT-1:0][ACC_W-1:0]     data_q, data_d;

  // NOTE: every always_comb output gets a default before any conditional
  // logic so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    valid_d = '0;
    data_d  = '0;
    prod    = {{FAC_W{1'b0}}, in_a} * {{ACC_W{1'b0}}, in_b};
    valid_d[0] = in_valid;
    data_d[0]  = ACC_W'(prod >> FAC_FRAC);
    for (int i = 1; i < MUL_LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // NOTE: the data stages carry no reset; they are only observed when the
  // matching valid bit is set, and clearing valid discards any in-flight value.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign out_valid = valid_q[MUL_LAT-1];
  assign out_data  = data_q[MUL_LAT-1];

endmodule

// File: rtl/backbone_mult_scheduler.sv
// -----------------------------------------------------------------------------
// backbone_mult_scheduler
//   Round-robin scheduler sharing one pipelined fixed-point multiplier among
//   NREQ requesters. Each accepted job is the serial product of NF Q0.8
//   factors, returned as a Q4.28 value tagged with the requester index.
//
//   Ports:
//     clk, rst_n    clock, asynchronous active-low reset
//     req_valid     per-requester request, held until req_ready
//     req_factors   requester r factor k at [(r*NF+k)*8 +: 8]
//     req_ready     one-hot, single-cycle accept pulse (registered)
//     res_valid     result available, held until res_ready
//     res_data      product, Q4.28
//     res_id        requester index of res_data
//     res_ready     consumer accepts result
//     busy          high whenever the FSM is not IDLE
//
//   Build option:
//     BACKBONE_SCHED_ZERO_SKIP_EN - a job containing any 0x00 factor goes
//     straight to DONE with a zero result and issues no multiplies.
// -----------------------------------------------------------------------------
module backbone_mult_scheduler
  import backbone_sched_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int NF      = 13,
  parameter  int MUL_LAT = 3,
  localparam int ID_W    = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*NF*FAC_W-1:0]  req_factors,
  output logic [NREQ-1:0]           req_ready,
  output logic                      res_valid,
  output logic [ACC_W-1:0]          res_data,
  output logic [ID_W-1:0]           res_id,
  input  logic                      res_ready,
  output logic                      busy
);

  localparam int K_W = $clog2(NF);

  state_e                   state_q, state_d;
  logic [ID_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]          id_q, id_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [K_W-1:0]           k_q, k_d;
  logic [NF-1:0][FAC_W-1:0] fac_q, fac_d;
  logic [NREQ-1:0]          req_ready_q, req_ready_d;

  logic                     grant_found;
  logic [ID_W-1:0]          grant_idx;
  logic [ID_W-1:0]          arb_cand;

  logic                     mul_in_valid;
  logic [FAC_W-1:0]         mul_in_b;
  logic                     mul_out_valid;
  logic [ACC_W-1:0]         mul_out_data;

`ifdef BACKBONE_SCHED_ZERO_SKIP_EN
  logic                     any_zero;
`endif

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: priority search starting at rr_ptr and wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    arb_cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      arb_cand = ID_W'((int'(rr_ptr_q) + i) % NREQ);
      if (!grant_found && req_valid[arb_cand]) begin
        grant_found = 1'b1;
        grant_idx   = arb_cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scheduler FSM: next state and datapath updates.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    acc_d       = acc_q;
    k_d         = k_q;
    fac_d       = fac_q;
    req_ready_d = '0;
`ifdef BACKBONE_SCHED_ZERO_SKIP_EN
    any_zero    = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready_d[grant_idx] = 1'b1;
          id_d                   = grant_idx;
          for (int k = 0; k < NF; k++) begin
            fac_d[k] = req_factors[(int'(grant_idx) * NF + k) * FAC_W +: FAC_W];
          end
          // Factor 0 seeds the accumulator; the multiplies start at factor 1.
          acc_d   = q08_to_q428(fac_d[0]);
          k_d     = K_W'(1);
          state_d = ISSUE;
`ifdef BACKBONE_SCHED_ZERO_SKIP_EN
          for (int k = 0; k < NF; k++) begin
            if (fac_d[k] == '0) any_zero = 1'b1;
          end
          if (any_zero) begin
            acc_d   = '0;
            state_d = DONE;
          end
`endif
        end
      end

      ISSUE: begin
        state_d = WAIT;
      end

      WAIT: begin
        // Only one multiply is ever in flight, so the next out_valid is ours.
        if (mul_out_valid) begin
          acc_d   = mul_out_data;
          k_d     = k_q + 1'b1;
          state_d = (k_q == K_W'(NF - 1)) ? DONE : ISSUE;
        end
      end

      DONE: begin
        if (res_ready) begin
          rr_ptr_d = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + 1'b1;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      req_ready_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      req_ready_q <= req_ready_d;
    end
  end

  // The latched factor vector is rewritten on every accept before use.
  always_ff @(posedge clk) begin
    fac_q <= fac_d;
  end

  // ---------------------------------------------------------------------------
  // Shared multiplier
  // ---------------------------------------------------------------------------
  assign mul_in_valid = (state_q == ISSUE);
  assign mul_in_b     = fac_q[k_q];

  mul_fix_pipe #(
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (mul_in_valid),
    .in_a      (acc_q),
    .in_b      (mul_in_b),
    .out_valid (mul_out_valid),
    .out_data  (mul_out_data)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready = req_ready_q;
  assign res_valid = (state_q == DONE);
  assign res_data  = acc_q;
  assign res_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_backbone_mult_scheduler.sv
// -----------------------------------------------------------------------------
// tb_backbone_mult_scheduler
//   Directed testbench for backbone_mult_scheduler with hand-computed results.
// -----------------------------------------------------------------------------
module tb_backbone_mult_scheduler;

  localparam int NREQ    = 4;
  localparam int NF      = 13;
  localparam int MUL_LAT = 3;
  localparam int ID_W    = 2;
  localparam int JOB_LAT = (NF - 1) * (MUL_LAT + 1);  // 48 cycles after accept
  localparam int VEC_W   = NF * 8;

`ifdef BACKBONE_SCHED_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NREQ-1:0]         req_valid = '0;
  logic [NREQ*VEC_W-1:0]   req_factors = '0;
  logic [NREQ-1:0]         req_ready;
  logic                    res_valid;
  logic [31:0]             res_data;
  logic [ID_W-1:0]         res_id;
  logic                    res_ready = 1'b0;
  logic                    busy;

  int n_checks  = 0;
  int n_errors  = 0;
  int cyc       = 0;
  int issue_cnt = 0;

  backbone_mult_scheduler #(
    .NREQ    (NREQ),
    .NF      (NF),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_factors (req_factors),
    .req_ready   (req_ready),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_id      (res_id),
    .res_ready   (res_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dut.mul_in_valid) issue_cnt <= issue_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] fac_vec(input logic [7:0] f0, input logic [7:0] rest);
    logic [VEC_W-1:0] v;
    v = '0;
    v[7:0] = f0;
    for (int k = 1; k < NF; k++) v[k*8 +: 8] = rest;
    return v;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic wait_grant(input int r, output int c);
    c = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) check("grant_timeout", 32'(req_ready[r]), 1);
  endtask

  task automatic wait_res(output int c);
    c = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (res_valid) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) check("res_timeout", 32'(res_valid), 1);
  endtask

  // One-cycle res_ready pulse: exactly one transfer, then back to IDLE.
  task automatic complete(input string tag);
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    check({tag, "_valid_after_xfer"}, 32'(res_valid), 0);
    check({tag, "_busy_after_xfer"}, 32'(busy), 0);
  endtask

  task automatic run_job(input int r, input logic [VEC_W-1:0] vec, input logic [31:0] exp_data,
                         input int exp_lat, input int exp_iss, input string tag);
    int c0, c1, c2, base;
    @(posedge clk); #1;
    req_factors[r*VEC_W +: VEC_W] = vec;
    req_valid[r] = 1'b1;
    c0   = cyc;
    base = issue_cnt;
    wait_grant(r, c1);
    check({tag, "_accept_lat"}, c1 - c0, 1);
    c2 = res_valid ? c1 : -1;
    @(posedge clk); #1 req_valid[r] = 1'b0;
    if (c2 < 0) wait_res(c2);
    check({tag, "_res_lat"}, c2 - c1, exp_lat);
    check({tag, "_data"}, res_data, exp_data);
    check({tag, "_id"}, 32'(res_id), r);
    check({tag, "_issues"}, issue_cnt - base, exp_iss);
    complete(tag);
  endtask

  initial begin
    logic [VEC_W-1:0] v;
    int c1, c2, g_seen;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_id", 32'(res_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // ---------------- single jobs ----------------
    // 0.5^13 in Q4.28 = 2^15
    run_job(2, fac_vec(8'h80, 8'h80), 32'h0000_8000, JOB_LAT, NF - 1, "half");
    // (0xFF<<20) >> 12
    run_job(1, fac_vec(8'hFF, 8'h80), 32'h0000_FF00, JOB_LAT, NF - 1, "ff_first");
    // 0x04000000 * 0.75 = 0x03000000, then >> 11
    v = fac_vec(8'h40, 8'h80);
    v[15:8] = 8'hC0;
    run_job(0, v, 32'h0000_6000, JOB_LAT, NF - 1, "mixed");
    // 0xFF<<20 -> 0xFF000 -> 0xFF0 -> 0xF, then nine x0xFF steps each lose 1 -> 6
    v = fac_vec(8'hFF, 8'hFF);
    for (int k = 1; k <= 3; k++) v[k*8 +: 8] = 8'h01;
    run_job(3, v, 32'h0000_0006, JOB_LAT, NF - 1, "trunc");
    // zero factor 3
    v = fac_vec(8'h80, 8'h80);
    v[3*8 +: 8] = 8'h00;
    run_job(1, v, 32'h0000_0000, ZS ? 0 : JOB_LAT, ZS ? 0 : NF - 1, "zero_f3");

    // ---------------- round robin, all requesting ----------------
    do_reset();
    for (int r = 0; r < NREQ; r++) req_factors[r*VEC_W +: VEC_W] = fac_vec(8'h80, 8'h80);
    res_ready = 1'b1;
    req_valid = '1;
    for (int g = 0; g < 8; g++) begin
      g_seen = 0;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        if (req_ready != '0) begin
          g_seen = 1;
          break;
        end
      end
      check($sformatf("rr_grant_%0d", g), 32'(req_ready), 32'(1) << (g % NREQ));
      @(negedge clk);
      check($sformatf("rr_pulse_%0d", g), 32'(req_ready), 0);
      if (g >= NREQ) begin
        @(posedge clk); #1 req_valid[g % NREQ] = 1'b0;
      end
      if (g_seen == 0) break;
    end
    for (int n = 0; n < 200 && busy; n++) @(negedge clk);
    check("rr_drain_busy", 32'(busy), 0);
    @(posedge clk); #1 res_ready = 1'b0;

    // ---------------- result held under backpressure ----------------
    @(posedge clk); #1;
    req_factors[3*VEC_W +: VEC_W] = fac_vec(8'h80, 8'h80);
    req_valid[3] = 1'b1;
    wait_grant(3, c1);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    req_factors[0 +: VEC_W] = fac_vec(8'h03, 8'h80);
    req_valid[0] = 1'b1;
    wait_res(c2);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 32'(res_valid), 1);
      check("hold_data", res_data, 32'h0000_8000);
      check("hold_id", 32'(res_id), 3);
      check("hold_busy", 32'(busy), 1);
      check("hold_no_grant", 32'(req_ready), 0);
      @(negedge clk);
    end
    complete("hold");
    // rr_ptr wraps 3 -> 0, so the waiting requester 0 is next
    wait_grant(0, c1);
    check("wrap_grant", 32'(req_ready), 32'b0001);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    wait_res(c2);
    check("wrap_lat", c2 - c1, JOB_LAT);
    check("wrap_data", res_data, 32'h0000_0300);
    check("wrap_id", 32'(res_id), 0);
    complete("wrap");

    // ---------------- reset in WAIT of step 5 ----------------
    @(posedge clk); #1;
    req_factors[2*VEC_W +: VEC_W] = fac_vec(8'hFF, 8'h80);
    req_valid[2] = 1'b1;
    wait_grant(2, c1);
    @(posedge clk); #1 req_valid[2] = 1'b0;
    // step 5 issues at c1+16; c1+18 is in its WAIT
    for (int n = 0; n < 40 && cyc < c1 + 18; n++) @(negedge clk);
    check("mid_busy", 32'(busy), 1);
    check("mid_state_wait", 32'(dut.state_q), 2);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_res_valid", 32'(res_valid), 0);
    check("mid_rst_res_data", res_data, 0);
    check("mid_rst_res_id", 32'(res_id), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_req_ready", 32'(req_ready), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    v = fac_vec(8'h40, 8'h80);
    v[15:8] = 8'hC0;
    run_job(1, v, 32'h0000_6000, JOB_LAT, NF - 1, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
